// File: rtl/display_framebuffer_arbiter.sv
// Double-buffered frame store arbiter: the display driver reads the front
// bank with absolute priority, host writes drain from a small FIFO into the
// back bank in idle cycles, and bank swaps happen only on frame_complete.
//
// state   | meaning
// IDLE    | no swap requested
// PENDING | swap requested, waits for frame_complete with an empty FIFO
module display_framebuffer_arbiter #(
  parameter  int rows       = 8,
  parameter  int columns    = 32,
  parameter  int bitwidth   = 8,
  parameter  int fifo_depth = 4,
  localparam int row_w      = $clog2(rows),
  localparam int col_w      = $clog2(columns),
  localparam int addr_w     = 1 + row_w + col_w,
  localparam int pix_w      = 3 * bitwidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_complete,
  input  logic              disp_req,
  input  logic [row_w-1:0]  disp_row,
  input  logic [col_w-1:0]  disp_col,
  output logic [pix_w-1:0]  disp_pixel,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [row_w-1:0]  wr_row,
  input  logic [col_w-1:0]  wr_col,
  input  logic [pix_w-1:0]  wr_data,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_bank,
  output logic [addr_w-1:0] mem_addr,
  output logic              mem_we,
  output logic [pix_w-1:0]  mem_wdata,
  input  logic [pix_w-1:0]  mem_rdata
);

  localparam int ptr_w   = $clog2(fifo_depth);
  localparam int cnt_w   = ptr_w + 1;
  localparam int entry_w = row_w + col_w + pix_w;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [entry_w-1:0] fifo_mem [fifo_depth];
  logic [ptr_w-1:0]   wr_ptr, rd_ptr;
  logic [cnt_w-1:0]   count_q;
  logic               ready_q;
  logic               fifo_empty, push, pop, rd_sel, swap_go;
  logic [entry_w-1:0] head;
  logic [addr_w-1:0]  addr_q;
  logic               rd_pend_q;
  logic [0:0]         state_q;

  assign fifo_empty   = (count_q == '0);
  assign wr_ready     = ready_q && (count_q < cnt_w'(fifo_depth));
  assign push         = wr_valid && wr_ready;
  // rst gates the read path so the memory port stays quiet while in reset
  assign rd_sel       = rst && disp_req;
  assign pop          = rst && !disp_req && !fifo_empty;
  assign head         = fifo_mem[rd_ptr];
  assign swap_go      = (state_q == PENDING) && frame_complete && fifo_empty && !pop;
  assign swap_pending = (state_q == PENDING);

  // memory port arbitration: display read, else FIFO drain, else hold address
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = head[pix_w-1:0];
    if (rd_sel) begin
      mem_addr = {front_bank, disp_row, disp_col};
    end else if (pop) begin
      mem_addr = {~front_bank, head[entry_w-1 -: row_w], head[pix_w +: col_w]};
      mem_we   = 1'b1;
    end
  end

  // last driven address, so an idle port does not toggle the address bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= mem_addr;
  end

  // host accepts writes only from the first clock after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // FIFO storage, no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {wr_row, wr_col, wr_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // two-stage read pipeline: RAM latency, then registered pixel output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      disp_valid <= 1'b0;
      disp_pixel <= '0;
    end else begin
      rd_pend_q  <= rd_sel;
      disp_valid <= rd_pend_q;
      if (rd_pend_q) disp_pixel <= mem_rdata;
    end
  end

  // swap sequencing; the bank toggles only when no write is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      swap_done <= swap_go;
      if (swap_go) front_bank <= ~front_bank;
      case (state_q)
        IDLE:    if (swap_req) state_q <= PENDING;
        PENDING: if (swap_go)  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_framebuffer_arbiter.sv
// Scoreboard bench for display_framebuffer_arbiter: expected pixels and RAM
// writes are queued at issue time and checked by an independent monitor.
module tb_display_framebuffer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_complete, disp_req, wr_valid, swap_req;
  logic [2:0]  disp_row, wr_row;
  logic [4:0]  disp_col, wr_col;
  logic [23:0] wr_data, disp_pixel, mem_wdata, mem_rdata;
  logic        disp_valid, wr_ready, swap_pending, swap_done, front_bank, mem_we;
  logic [8:0]  mem_addr;

  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [23:0] pre_data;
  logic [23:0] ram     [512];
  logic [23:0] exp_mem [512];

  typedef struct { int cyc; logic [23:0] px; } rd_exp_t;
  typedef struct { logic [8:0] addr; logic [23:0] data; } wr_exp_t;
  rd_exp_t rq[$];
  wr_exp_t wq[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic fb_m  = 1'b0;

  display_framebuffer_arbiter dut (
    .clk(clk), .rst(rst), .frame_complete(frame_complete),
    .disp_req(disp_req), .disp_row(disp_row), .disp_col(disp_col),
    .disp_pixel(disp_pixel), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .swap_req(swap_req), .swap_pending(swap_pending),
    .swap_done(swap_done), .front_bank(front_bank), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // single-port synchronous RAM with a bench-only preload port
  always @(posedge clk) begin
    if (pre_we)      ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pat(int r, int c);
    return {8'(r * 16 + c), 8'(c * 7), 8'(224 + r)};
  endfunction

  // issue one display read this cycle; caller ticks once afterwards
  task automatic rd(input int r, input int c);
    rd_exp_t e;
    disp_req = 1'b1;
    disp_row = 3'(r);
    disp_col = 5'(c);
    e.cyc = cyc;
    e.px  = exp_mem[{fb_m, 3'(r), 5'(c)}];
    rq.push_back(e);
  endtask

  // offer one host write and wait (bounded) for acceptance
  task automatic host_write(input int r, input int c, input logic [23:0] d);
    wr_exp_t e;
    wr_valid = 1'b1;
    wr_row   = 3'(r);
    wr_col   = 5'(c);
    wr_data  = d;
    for (int k = 0; k < 50 && !wr_ready; k++) tick();
    chk("wr_accept", wr_ready, 1'b1);
    if (wr_ready) begin
      e.addr = {~fb_m, 3'(r), 5'(c)};
      e.data = d;
      wq.push_back(e);
    end
    tick();
  endtask

  // monitor: pops expectations whenever the DUT presents a pixel or a write
  initial begin
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge clk);
      if (disp_valid) begin
        chk("rd_queue", rq.size() != 0, 1'b1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          chk("disp_pixel", disp_pixel, re.px);
          chk("rd_latency", cyc, re.cyc + 2);
        end
      end
      if (mem_we) begin
        chk("wr_queue", wq.size() != 0, 1'b1);
        if (wq.size() != 0) begin
          we = wq.pop_front();
          chk("mem_addr", mem_addr, we.addr);
          chk("mem_wdata", mem_wdata, we.data);
          exp_mem[we.addr] = we.data;
        end
      end
      if (disp_req) chk("prio_no_we", mem_we, 1'b0);
    end
  end

  initial begin
    int wi;
    wr_exp_t e;
    rst = 1'b0;
    frame_complete = 0; disp_req = 0; wr_valid = 0; swap_req = 0;
    disp_row = 0; disp_col = 0; wr_row = 0; wr_col = 0; wr_data = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;

    // preload during reset; bank0 {3,5} carries the known fetch pixel
    for (int a = 0; a < 512; a++) begin
      pre_we   = 1'b1;
      pre_addr = 9'(a);
      pre_data = (a == 101) ? 24'h123456 : (24'hC00000 | 24'(a));
      exp_mem[a] = pre_data;
      tick();
    end
    pre_we   = 1'b0;
    disp_req = 1'b1;
    disp_row = 3'd3;
    disp_col = 5'd5;
    #1;
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_disp_valid", disp_valid, 1'b0);
    chk("rst_disp_pixel", disp_pixel, 24'h0);
    chk("rst_swap_pending", swap_pending, 1'b0);
    chk("rst_swap_done", swap_done, 1'b0);
    chk("rst_front_bank", front_bank, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 9'h0);
    disp_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rel_wr_ready", wr_ready, 1'b1);

    // fetch bank0 row 3 col 5
    rd(3, 5);
    tick();
    disp_req = 1'b0;
    repeat (3) tick();

    // priority: display holds the port, host fills the FIFO and stalls
    wi = 0;
    for (int i = 0; i < 10; i++) begin
      rd(0, i);
      if (wi < 5) begin
        wr_valid = 1'b1;
        wr_row   = 3'(wi);
        wr_col   = 5'(10 + wi);
        wr_data  = 24'hB00000 + 24'(wi);
      end
      if (wr_valid && wr_ready) begin
        e.addr = {~fb_m, wr_row, wr_col};
        e.data = wr_data;
        wq.push_back(e);
        wi++;
      end
      tick();
    end
    chk("prio_accepts", wi, 4);
    chk("prio_ready_low", wr_ready, 1'b0);
    wr_valid = 1'b0;
    disp_req = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", mem_we, 1'b1);
      tick();
    end
    chk("drain_done", mem_we, 1'b0);
    repeat (2) tick();

    // deferred swap: FIFO non-empty at the first frame_complete
    rd(7, 0); host_write(5, 0, 24'hD00000);
    rd(7, 1); host_write(5, 1, 24'hD00001);
    wr_valid = 1'b0;
    rd(7, 2); swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("def_pending", swap_pending, 1'b1);
    rd(7, 3); frame_complete = 1'b1; tick(); frame_complete = 1'b0;
    chk("def_still_pending", swap_pending, 1'b1);
    chk("def_front_hold", front_bank, 1'b0);
    chk("def_no_done", swap_done, 1'b0);
    disp_req = 1'b0;
    repeat (3) tick();
    frame_complete = 1'b1; fb_m = 1'b1; tick(); frame_complete = 1'b0;
    chk("def_done", swap_done, 1'b1);
    chk("def_front", front_bank, 1'b1);
    chk("def_idle", swap_pending, 1'b0);
    rd(2, 12); tick();
    chk("def_done_pulse", swap_done, 1'b0);
    rd(5, 1); tick();
    disp_req = 1'b0;
    repeat (3) tick();

    // full-frame sweep: write pattern to back bank, swap, read, swap back
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 32; c++)
        host_write(r, c, pat(r, c));
    wr_valid = 1'b0;
    repeat (3) tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    frame_complete = 1'b1; fb_m = 1'b0; tick(); frame_complete = 1'b0;
    chk("sweep_front0", front_bank, 1'b0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 32; c++) begin
        rd(r, c);
        tick();
      end
    disp_req = 1'b0;
    repeat (3) tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    frame_complete = 1'b1; fb_m = 1'b1; tick(); frame_complete = 1'b0;
    chk("sweep_front1", front_bank, 1'b1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 32; c++) begin
        rd(r, c);
        tick();
      end
    disp_req = 1'b0;
    repeat (3) tick();

    // reset mid-operation with 3 queued writes and a pending swap
    rd(1, 1); host_write(6, 0, 24'hEE0000);
    rd(1, 2); host_write(6, 1, 24'hEE0001);
    rd(1, 3); host_write(6, 2, 24'hEE0002);
    wr_valid = 1'b0;
    rd(1, 4); swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("mid_pending", swap_pending, 1'b1);
    rd(1, 5);
    rst = 1'b0;
    rq.delete();
    wq.delete();
    #1;
    chk("mid_wr_ready", wr_ready, 1'b0);
    chk("mid_swap_pending", swap_pending, 1'b0);
    chk("mid_front_bank", front_bank, 1'b0);
    chk("mid_disp_valid", disp_valid, 1'b0);
    chk("mid_disp_pixel", disp_pixel, 24'h0);
    chk("mid_mem_we", mem_we, 1'b0);
    chk("mid_mem_addr", mem_addr, 9'h0);
    repeat (2) tick();
    disp_req = 1'b0;
    rst = 1'b1;
    fb_m = 1'b0;
    tick();
    chk("mid_rel_ready", wr_ready, 1'b1);
    chk("mid_rel_front", front_bank, 1'b0);
    chk("mid_rel_pending", swap_pending, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_we", mem_we, 1'b0);
      tick();
    end

    // swap_req coincident with frame_complete in IDLE
    swap_req = 1'b1; frame_complete = 1'b1; tick();
    swap_req = 1'b0; frame_complete = 1'b0;
    chk("coin_pending", swap_pending, 1'b1);
    chk("coin_front", front_bank, 1'b0);
    chk("coin_no_done", swap_done, 1'b0);
    tick();
    frame_complete = 1'b1; fb_m = 1'b1; tick(); frame_complete = 1'b0;
    chk("coin_done", swap_done, 1'b1);
    chk("coin_toggle", front_bank, 1'b1);
    rd(5, 0); tick();
    disp_req = 1'b0;
    repeat (4) tick();

    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
